// File: rtl/mips_core_pkg.sv
// Shared fetch/decode types for the MIPS core.
package mips_core_pkg;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } BranchOutcome;

endpackage

// File: rtl/branch_predictor_btb_sat_counter.sv
// Saturating up/down counter with synchronous clear and parallel load.
// Priority: clr > load > inc > dec. It never wraps in either direction.
module sat_counter #(
  parameter int unsigned           WIDTH     = 2,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next-count selection with saturation at both ends.
  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = RESET_VAL;
    else if (load)
      count_d = load_val;
    else if (inc && (count_q != '1))
      count_d = count_q + WIDTH'(1);
    else if (dec && (count_q != '0))
      count_d = count_q - WIDTH'(1);
  end

  // Counter register, asynchronously returned to its reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= RESET_VAL;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, optional
// gshare indexing and saturating resolution/mispredict statistics.
module branch_predictor_btb
  import mips_core_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned TAG_BITS   = 8,
  parameter int unsigned CTR_BITS   = 2,
  parameter int unsigned GHR_BITS   = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] fetch_pc,
  output logic                  pred_valid,
  output logic [ADDR_WIDTH-1:0] pred_target,
  output BranchOutcome          pred_outcome,
  input  logic                  res_valid,
  input  logic [ADDR_WIDTH-1:0] res_pc,
  input  logic [ADDR_WIDTH-1:0] res_target,
  input  BranchOutcome          res_prediction,
  input  BranchOutcome          res_outcome,
  output logic [CNT_WIDTH-1:0]  stat_resolved,
  output logic [CNT_WIDTH-1:0]  stat_mispredict
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_NT = CTR_BITS'((1 << (CTR_BITS - 1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));

  logic [ENTRIES-1:0]    valid_q, valid_d;
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [TAG_BITS-1:0]   tag_d    [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_q [ENTRIES];
  logic [ADDR_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_val  [ENTRIES];

  logic [INDEX_BITS-1:0] ghr_idx;
  logic [INDEX_BITS-1:0] f_idx, r_idx;
  logic [TAG_BITS-1:0]   f_tag, r_tag;
  logic                  f_hit, r_hit, r_taken;
  logic                  upd_en, alloc, hit_inc, hit_dec;
  logic                  unused_pc_bits;

  // Only the index/tag fields of the PCs participate in the lookup.
  assign unused_pc_bits = ^{fetch_pc, res_pc};

  // Global history; absent in bimodal mode so the index XOR term is zero.
  if (GHR_BITS > 0) begin : g_ghr
    logic [GHR_BITS-1:0] ghr_q, ghr_d;
    logic [GHR_BITS:0]   ghr_shift;

    // Non-speculative history: shifts only on resolved branches.
    always_comb begin
      ghr_shift = {ghr_q, (res_outcome == TAKEN)};
      ghr_d     = ghr_q;
      if (clear)
        ghr_d = '0;
      else if (res_valid)
        ghr_d = ghr_shift[GHR_BITS-1:0];
    end

    // History register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) ghr_q <= '0;
      else     ghr_q <= ghr_d;
    end

    assign ghr_idx = INDEX_BITS'(ghr_q);
  end else begin : g_bimodal
    assign ghr_idx = '0;
  end

  // Index/tag extraction for both the fetch lookup and the training port.
  always_comb begin
    f_idx   = fetch_pc[INDEX_BITS+1:2] ^ ghr_idx;
    f_tag   = fetch_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
    r_idx   = res_pc[INDEX_BITS+1:2] ^ ghr_idx;
    r_tag   = res_pc[TAG_BITS+INDEX_BITS+1:INDEX_BITS+2];
    f_hit   = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    r_hit   = valid_q[r_idx] && (tag_q[r_idx] == r_tag);
    r_taken = (res_outcome == TAKEN);
    upd_en  = res_valid && !clear;
    alloc   = upd_en && !r_hit && r_taken;
    hit_inc = upd_en && r_hit && r_taken;
    hit_dec = upd_en && r_hit && !r_taken;
  end

  // Zero-latency prediction from registered table state (no bypass).
  always_comb begin
    pred_valid   = 1'b0;
    pred_target  = '0;
    pred_outcome = NOT_TAKEN;
    if (f_hit) begin
      pred_valid   = 1'b1;
      pred_target  = target_q[f_idx];
      pred_outcome = ctr_val[f_idx][CTR_BITS-1] ? TAKEN : NOT_TAKEN;
    end
  end

  // Table next-state: clear wins over allocation/target refresh.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (clear) begin
      valid_d = '0;
    end else if (alloc) begin
      valid_d[r_idx]  = 1'b1;
      tag_d[r_idx]    = r_tag;
      target_d[r_idx] = res_target;
    end else if (hit_inc) begin
      target_d[r_idx] = res_target;
    end
  end

  // Valid bits are the only table state that needs a reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Tag/target payload; meaningless until the matching valid bit is set.
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  // One direction counter per entry.
  for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
    logic sel;
    assign sel = (r_idx == INDEX_BITS'(i));

    sat_counter #(
      .WIDTH     (CTR_BITS),
      .RESET_VAL (CTR_WEAK_NT)
    ) u_ctr (
      .clk      (clk),
      .rst      (rst),
      .clr      (clear),
      .load     (alloc && sel),
      .load_val (CTR_WEAK_T),
      .inc      (hit_inc && sel),
      .dec      (hit_dec && sel),
      .count    (ctr_val[i])
    );
  end

  // Statistics ignore clear so dropped updates are still accounted for.
  sat_counter #(
    .WIDTH     (CNT_WIDTH),
    .RESET_VAL ('0)
  ) u_stat_resolved (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (res_valid),
    .dec      (1'b0),
    .count    (stat_resolved)
  );

  sat_counter #(
    .WIDTH     (CNT_WIDTH),
    .RESET_VAL ('0)
  ) u_stat_mispredict (
    .clk      (clk),
    .rst      (rst),
    .clr      (1'b0),
    .load     (1'b0),
    .load_val ('0),
    .inc      (res_valid && (res_prediction != res_outcome)),
    .dec      (1'b0),
    .count    (stat_mispredict)
  );

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Directed bench: bimodal instance (defaults) and a gshare instance with
// narrow statistics, sharing one stimulus stream.
module tb_branch_predictor_btb;
  import mips_core_pkg::*;

  logic         clk = 1'b0;
  logic         rst, clear, res_valid;
  logic [31:0]  fetch_pc, res_pc, res_target;
  BranchOutcome res_prediction, res_outcome;

  logic         a_valid, b_valid;
  logic [31:0]  a_target, b_target;
  BranchOutcome a_outcome, b_outcome;
  logic [31:0]  a_resolved, a_mis;
  logic [2:0]   b_resolved, b_mis;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  localparam logic [31:0] PC_A = 32'h0040_0010;
  localparam logic [31:0] PC_B = 32'h0040_0020;
  localparam logic [31:0] PC_C = 32'h0040_1010;
  localparam logic [31:0] PC_D = 32'h0040_0040;
  localparam logic [31:0] PC_E = 32'h0040_0080;

  branch_predictor_btb dut_a (
    .clk(clk), .rst(rst), .clear(clear), .fetch_pc(fetch_pc),
    .pred_valid(a_valid), .pred_target(a_target), .pred_outcome(a_outcome),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target),
    .res_prediction(res_prediction), .res_outcome(res_outcome),
    .stat_resolved(a_resolved), .stat_mispredict(a_mis)
  );

  branch_predictor_btb #(.GHR_BITS(2), .CNT_WIDTH(3)) dut_b (
    .clk(clk), .rst(rst), .clear(clear), .fetch_pc(fetch_pc),
    .pred_valid(b_valid), .pred_target(b_target), .pred_outcome(b_outcome),
    .res_valid(res_valid), .res_pc(res_pc), .res_target(res_target),
    .res_prediction(res_prediction), .res_outcome(res_outcome),
    .stat_resolved(b_resolved), .stat_mispredict(b_mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic resolve(input logic [31:0] pc, input logic [31:0] tgt,
                         input BranchOutcome pred, input BranchOutcome outc);
    res_valid      = 1'b1;
    res_pc         = pc;
    res_target     = tgt;
    res_prediction = pred;
    res_outcome    = outc;
    tick();
    res_valid      = 1'b0;
  endtask

  task automatic look(input logic [31:0] pc);
    fetch_pc = pc;
    #1;
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; res_valid = 1'b0;
    fetch_pc = '0; res_pc = '0; res_target = '0;
    res_prediction = NOT_TAKEN; res_outcome = NOT_TAKEN;
    tick(); tick();
    rst = 1'b0;

    // ---- bimodal instance ----
    look(PC_A);
    check("rst_valid",   a_valid,    0);
    check("rst_outcome", a_outcome,  NOT_TAKEN);
    check("rst_target",  a_target,   0);
    check("rst_res",     a_resolved, 0);
    check("rst_mis",     a_mis,      0);

    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, TAKEN);        // alloc, ctr 10
    look(PC_A);
    check("alloc_valid",   a_valid,    1);
    check("alloc_outcome", a_outcome,  TAKEN);
    check("alloc_target",  a_target,   32'h0040_0100);
    check("alloc_mis",     a_mis,      1);
    check("alloc_res",     a_resolved, 1);

    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, NOT_TAKEN);    // ctr 01
    look(PC_A);
    check("dec1_valid",   a_valid,   1);
    check("dec1_outcome", a_outcome, NOT_TAKEN);
    check("dec1_target",  a_target,  32'h0040_0100);

    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, NOT_TAKEN);    // ctr 00
    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, NOT_TAKEN);    // stays 00
    look(PC_A);
    check("dec3_outcome", a_outcome, NOT_TAKEN);

    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, TAKEN);        // ctr 01
    look(PC_A);
    check("inc1_outcome", a_outcome, NOT_TAKEN);

    resolve(PC_A, 32'h0040_0200, NOT_TAKEN, TAKEN);        // ctr 10, new target
    look(PC_A);
    check("inc2_outcome", a_outcome, TAKEN);
    check("inc2_target",  a_target,  32'h0040_0200);

    resolve(PC_A, 32'h0040_0200, NOT_TAKEN, TAKEN);        // ctr 11
    resolve(PC_A, 32'h0040_0200, NOT_TAKEN, TAKEN);        // stays 11
    resolve(PC_A, 32'h0040_0999, NOT_TAKEN, NOT_TAKEN);    // ctr 10, target kept
    look(PC_A);
    check("sat_hi_outcome", a_outcome, TAKEN);
    check("nt_keeps_target", a_target, 32'h0040_0200);

    resolve(PC_A, 32'h0040_0200, NOT_TAKEN, NOT_TAKEN);    // ctr 01
    look(PC_A);
    check("sat_hi_dec2", a_outcome, NOT_TAKEN);
    check("stats_res10", a_resolved, 10);
    check("stats_mis5",  a_mis,      5);

    resolve(PC_B, 32'h0040_0800, NOT_TAKEN, NOT_TAKEN);    // miss NT: no alloc
    look(PC_B);
    check("miss_nt_noalloc", a_valid, 0);

    resolve(PC_C, 32'h0050_0000, NOT_TAKEN, TAKEN);        // same idx, new tag
    look(PC_C);
    check("alias_valid",   a_valid,   1);
    check("alias_outcome", a_outcome, TAKEN);
    check("alias_target",  a_target,  32'h0050_0000);
    look(PC_A);
    check("alias_evicted", a_valid, 0);

    resolve(PC_C, 32'h0050_0000, NOT_TAKEN, NOT_TAKEN);    // 10 -> 01
    look(PC_C);
    check("alias_dec",  a_outcome,  NOT_TAKEN);
    check("stats_res13", a_resolved, 13);
    check("stats_mis6",  a_mis,      6);

    // same-cycle lookup/update: no bypass
    res_valid = 1'b1; res_pc = PC_D; res_target = 32'h0040_0400;
    res_prediction = NOT_TAKEN; res_outcome = TAKEN;
    look(PC_D);
    check("same_cycle_pre", a_valid, 0);
    tick();
    res_valid = 1'b0;
    #1;
    check("same_cycle_post",   a_valid,  1);
    check("same_cycle_target", a_target, 32'h0040_0400);

    // clear with a simultaneous allocation: update dropped, stats still count
    res_valid = 1'b1; res_pc = PC_E; res_target = 32'h0040_0500;
    res_prediction = NOT_TAKEN; res_outcome = TAKEN;
    clear = 1'b1;
    fetch_pc = PC_E;
    tick();
    res_valid = 1'b0; clear = 1'b0;
    look(PC_E);
    check("clear_drop", a_valid, 0);
    look(PC_D);
    check("clear_d", a_valid, 0);
    look(PC_C);
    check("clear_c", a_valid, 0);
    check("clear_res15", a_resolved, 15);
    check("clear_mis8",  a_mis,      8);

    // async reset between edges
    rst = 1'b1;
    #1;
    check("arst_a_res", a_resolved, 0);
    check("arst_a_mis", a_mis,      0);
    check("arst_b_res", b_resolved, 0);
    tick();
    rst = 1'b0;

    // ---- gshare instance (GHR_BITS=2, CNT_WIDTH=3) ----
    look(PC_A);
    check("g_rst_valid", b_valid, 0);

    resolve(PC_A, 32'h0040_0100, NOT_TAKEN, TAKEN);        // alloc idx 4, GHR=01
    look(PC_A);
    check("g_idx_moved", b_valid, 0);
    look(32'h0040_0014);                                   // raw 5 ^ 1 = 4
    check("g_hit_x1_valid",  b_valid,  1);
    check("g_hit_x1_target", b_target, 32'h0040_0100);

    resolve(PC_A, 32'h0040_0300, NOT_TAKEN, TAKEN);        // idx 4^1=5, GHR=11
    look(32'h0040_001C);                                   // raw 7 ^ 3 = 4
    check("g_hit_x3_e4", b_target, 32'h0040_0100);
    look(32'h0040_0018);                                   // raw 6 ^ 3 = 5
    check("g_hit_x3_e5_valid", b_valid,  1);
    check("g_hit_x3_e5",       b_target, 32'h0040_0300);
    look(PC_A);
    check("g_x3_miss", b_valid, 0);
    check("g_res2", b_resolved, 2);
    check("g_mis2", b_mis,      2);

    for (int i = 0; i < 7; i++)
      resolve(PC_B, 32'h0, TAKEN, NOT_TAKEN);              // 9 mispredicts total
    check("g_mis_sat", b_mis,      7);
    check("g_res_sat", b_resolved, 7);

    look(PC_A);                                            // GHR back to 00
    check("g_ghr0_valid",   b_valid,   1);
    check("g_ghr0_outcome", b_outcome, TAKEN);

    rst = 1'b1;
    #1;
    check("g_arst_valid",   b_valid,    0);
    check("g_arst_target",  b_target,   0);
    check("g_arst_outcome", b_outcome,  NOT_TAKEN);
    check("g_arst_res",     b_resolved, 0);
    check("g_arst_mis",     b_mis,      0);
    tick();
    rst = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
